// File: rtl/stream_pattern_gen.sv
// stream_pattern_gen
//   Source side of the stream comparison path. Produces a per-link counter or
//   PRBS-31 pattern and drives it on two AXI-Stream masters with identical
//   data. Stream 1 can carry a one-shot single-bit error so the downstream
//   comparator's mismatch detection can be exercised. Word and injected-error
//   counts are exported for cross-checking against the comparator.
//
// Ports
//   clk, aresetn          stream clock, asynchronous active-low reset
//   start, stop           run control pulses (stop wins when both are high)
//   mode                  0 = counter pattern, 1 = PRBS-31 (sampled at start)
//   n_words               words per run, 0 = continuous (sampled at start)
//   inject_err, inject_lane  arm a single-bit error on a link of stream 1
//   M_AXIS_0_*            reference stream
//   M_AXIS_1_*            stream under test (carries the injected error)
//   busy, done            state == RUN / state == DONE
//   words_sent            words accepted on both streams this run (saturating)
//   errs_injected         completed words that carried an error (saturating)
module stream_pattern_gen #(
    parameter int          TDATA_WIDTH = 32,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode,
    input  logic [31:0]            n_words,
    input  logic                   inject_err,
    input  logic [3:0]             inject_lane,
    output logic [TDATA_WIDTH-1:0] M_AXIS_0_TDATA,
    output logic                   M_AXIS_0_TVALID,
    input  logic                   M_AXIS_0_TREADY,
    output logic                   M_AXIS_0_TLAST,
    output logic [TDATA_WIDTH-1:0] M_AXIS_1_TDATA,
    output logic                   M_AXIS_1_TVALID,
    input  logic                   M_AXIS_1_TREADY,
    output logic                   M_AXIS_1_TLAST,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            words_sent,
    output logic [31:0]            errs_injected
);

    localparam int NLINKS = TDATA_WIDTH / 32;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic                         pending_q, pending_d;
    logic                         acc0_q, acc0_d, acc1_q, acc1_d;
    logic [TDATA_WIDTH-1:0]       data0_q, data1_q;
    logic                         last_q, last_d, err_q;
    logic                         bounded_q, mode_q, stopping_q, stopping_d;
    logic [31:0]                  rem_q, rem_d, cnt_q;
    logic [NLINKS-1:0][30:0]      prbs_q, prbs_nxt;
    logic [31:0]                  words_q, words_d, errs_q, errs_d;
    logic                         armed_q, armed_d;
    logic [3:0]                   lane_q, lane_d;

    logic                         start_go, hs0, hs1, comp, load;
    logic [31:0]                  src_cnt;
    logic [TDATA_WIDTH-1:0]       gen_word;

    // 32 serial steps of x^31+x^28+1; returns {word, advanced state}.
    function automatic logic [62:0] prbs_step32(input logic [30:0] s_in);
        logic [30:0] s;
        logic [31:0] w;
        logic        fb;
        s = s_in;
        w = '0;
        for (int j = 0; j < 32; j++) begin
            fb        = s[30] ^ s[27];
            s         = {s[29:0], fb};
            w[31 - j] = fb;
        end
        return {w, s};
    endfunction

    // Per-link seed; an all-zero state would lock the LFSR, so it becomes 1.
    function automatic logic [30:0] prbs_seed(input int link);
        logic [30:0] s;
        s = SEED[30:0] ^ 31'(link);
        if (s == '0) s = 31'd1;
        return s;
    endfunction

    function automatic logic [TDATA_WIDTH-1:0] lane_mask(input logic [3:0] lane);
        logic [TDATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < NLINKS; i++)
            if (lane == 4'(i)) m[32*i] = 1'b1;
        return m;
    endfunction

    // Output process
    always_comb begin
        M_AXIS_0_TVALID = pending_q & ~acc0_q;
        M_AXIS_1_TVALID = pending_q & ~acc1_q;
        M_AXIS_0_TLAST  = last_q & M_AXIS_0_TVALID;
        M_AXIS_1_TLAST  = last_q & M_AXIS_1_TVALID;
        M_AXIS_0_TDATA  = data0_q;
        M_AXIS_1_TDATA  = data1_q;
        busy            = (state_q == S_RUN);
        done            = (state_q == S_DONE);
        words_sent      = words_q;
        errs_injected   = errs_q;
    end

    assign start_go = start && !stop && (state_q != S_RUN);
    assign hs0      = M_AXIS_0_TVALID && M_AXIS_0_TREADY;
    assign hs1      = M_AXIS_1_TVALID && M_AXIS_1_TREADY;
    // A word completes once each stream has taken it, in any order.
    assign comp     = pending_q && (acc0_q || hs0) && (acc1_q || hs1);
    assign load     = start_go ||
                      ((state_q == S_RUN) && comp && !last_q && !stopping_q && !stop);

    // Pattern source: on start the generator restarts from the seed in the
    // same cycle so the first word is valid immediately after start.
    always_comb begin
        logic [62:0] r;
        logic        use_prbs;
        src_cnt  = start_go ? SEED : cnt_q;
        use_prbs = start_go ? mode : mode_q;
        gen_word = '0;
        prbs_nxt = prbs_q;
        for (int i = 0; i < NLINKS; i++) begin
            r = prbs_step32(start_go ? prbs_seed(i) : prbs_q[i]);
            prbs_nxt[i] = r[30:0];
            gen_word[32*i +: 32] = use_prbs ? r[62:31] : src_cnt + 32'(i);
        end
    end

    // Next-state process
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_go) state_d = S_RUN;
            S_RUN: begin
                if (comp && last_q)
                    state_d = S_DONE;
                else if ((stopping_q || stop) && (comp || !pending_q))
                    state_d = S_IDLE;
            end
            S_DONE: begin
                if (stop)          state_d = S_IDLE;
                else if (start_go) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pending_d  = load ? 1'b1 : (comp ? 1'b0 : pending_q);
        acc0_d     = (load || comp) ? 1'b0 : (acc0_q || hs0);
        acc1_d     = (load || comp) ? 1'b0 : (acc1_q || hs1);
        stopping_d = (state_q == S_RUN) && (stopping_q || stop);

        // rem_q counts words still to be loaded in a bounded run.
        if (start_go) begin
            last_d = (n_words == 32'd1);
            rem_d  = n_words - 32'd1;
        end else begin
            last_d = bounded_q && (rem_q == 32'd1);
            rem_d  = rem_q - 32'd1;
        end

        words_d = words_q;
        errs_d  = errs_q;
        if (start_go) begin
            words_d = '0;
            errs_d  = '0;
        end else if (comp) begin
            if (words_q != '1)          words_d = words_q + 32'd1;
            if (err_q && errs_q != '1)  errs_d  = errs_q + 32'd1;
        end

        // A fresh arm takes priority over the arm being consumed this cycle.
        armed_d = armed_q;
        lane_d  = lane_q;
        if (load && armed_q) armed_d = 1'b0;
        if (inject_err && (int'(inject_lane) < NLINKS)) begin
            armed_d = 1'b1;
            lane_d  = inject_lane;
        end
    end

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pending_q  <= 1'b0;
            acc0_q     <= 1'b0;
            acc1_q     <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            bounded_q  <= 1'b0;
            mode_q     <= 1'b0;
            stopping_q <= 1'b0;
            rem_q      <= '0;
            cnt_q      <= '0;
            prbs_q     <= '0;
            words_q    <= '0;
            errs_q     <= '0;
            armed_q    <= 1'b0;
            lane_q     <= '0;
        end else begin
            if (load) begin
                data0_q <= gen_word;
                data1_q <= gen_word ^ (armed_q ? lane_mask(lane_q) : '0);
                err_q   <= armed_q;
                last_q  <= last_d;
                rem_q   <= rem_d;
                cnt_q   <= src_cnt + 32'd1;
                prbs_q  <= prbs_nxt;
            end
            if (start_go) begin
                mode_q    <= mode;
                bounded_q <= (n_words != 32'd0);
            end
            pending_q  <= pending_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            stopping_q <= stopping_d;
            words_q    <= words_d;
            errs_q     <= errs_d;
            armed_q    <= armed_d;
            lane_q     <= lane_d;
        end
    end

endmodule

// File: tb/tb_stream_pattern_gen.sv
module tb_stream_pattern_gen;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        start, stop, mode, inject_err;
    logic [31:0] n_words;
    logic [3:0]  inject_lane;
    logic [63:0] d0, d1;
    logic        v0, v1, r0, r1, l0, l1;
    logic        busy, done;
    logic [31:0] words_sent, errs_injected;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stream_pattern_gen #(.TDATA_WIDTH(64), .SEED(32'h0000_0001)) dut (
        .clk(clk), .aresetn(aresetn), .start(start), .stop(stop), .mode(mode),
        .n_words(n_words), .inject_err(inject_err), .inject_lane(inject_lane),
        .M_AXIS_0_TDATA(d0), .M_AXIS_0_TVALID(v0), .M_AXIS_0_TREADY(r0), .M_AXIS_0_TLAST(l0),
        .M_AXIS_1_TDATA(d1), .M_AXIS_1_TVALID(v1), .M_AXIS_1_TREADY(r1), .M_AXIS_1_TLAST(l1),
        .busy(busy), .done(done), .words_sent(words_sent), .errs_injected(errs_injected)
    );

    typedef struct {
        logic        start, stop, rdy0, rdy1;
        logic [31:0] nw;
        logic        chk_d, v0, v1, last, busy, done;
        logic [63:0] d0, d1;
        logic [31:0] words;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic sp, input logic a, input logic b,
                                input logic [31:0] nw, input logic cd, input logic ev0,
                                input logic ev1, input logic el, input logic eb, input logic ed,
                                input logic [63:0] ed0, input logic [63:0] ed1,
                                input logic [31:0] ew);
        vec_t t;
        t.start = st; t.stop = sp; t.rdy0 = a; t.rdy1 = b; t.nw = nw;
        t.chk_d = cd; t.v0 = ev0; t.v1 = ev1; t.last = el; t.busy = eb; t.done = ed;
        t.d0 = ed0; t.d1 = ed1; t.words = ew;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] W0 = 64'h00000002_00000001;
    localparam logic [63:0] W1 = 64'h00000003_00000002;
    localparam logic [63:0] W2 = 64'h00000004_00000003;
    localparam logic [63:0] W3 = 64'h00000005_00000004;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   ndiff, diff_k, cyc;

        aresetn = 1'b0; start = 0; stop = 0; mode = 0; n_words = 0;
        inject_err = 0; inject_lane = 0; r0 = 1; r1 = 1;

        // reset state, then bounded 4-word counter run with both ready
        tbl.push_back(mk(1,0,1,1,4, 1, 0,0,0,0,0, 64'h0, 64'h0, 0));
        tbl.push_back(mk(0,0,1,1,0, 0, 1,1,0,1,0, W0, W0, 0));
        tbl.push_back(mk(0,0,1,1,0, 0, 1,1,0,1,0, W1, W1, 1));
        tbl.push_back(mk(0,0,1,1,0, 0, 1,1,0,1,0, W2, W2, 2));
        tbl.push_back(mk(0,0,1,1,0, 0, 1,1,1,1,0, W3, W3, 3));
        // restart from DONE: 3 words, stream 1 stalled for 5 cycles
        tbl.push_back(mk(1,0,1,0,3, 0, 0,0,0,0,1, 64'h0, 64'h0, 4));
        tbl.push_back(mk(0,0,1,0,0, 0, 1,1,0,1,0, W0, W0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,1,0,0, 0, 0,1,0,1,0, W0, W0, 0));
        tbl.push_back(mk(0,0,1,1,0, 0, 0,1,0,1,0, W0, W0, 0));
        tbl.push_back(mk(0,0,1,1,0, 0, 1,1,0,1,0, W1, W1, 1));
        tbl.push_back(mk(0,0,1,1,0, 0, 1,1,1,1,0, W2, W2, 2));
        // continuous run, stop while stream 1 is stalled mid-word
        tbl.push_back(mk(1,0,1,0,0, 0, 0,0,0,0,1, 64'h0, 64'h0, 3));
        tbl.push_back(mk(0,0,1,0,0, 0, 1,1,0,1,0, W0, W0, 0));
        tbl.push_back(mk(0,1,1,0,0, 0, 0,1,0,1,0, W0, W0, 0));
        tbl.push_back(mk(0,0,1,0,0, 0, 0,1,0,1,0, W0, W0, 0));
        tbl.push_back(mk(0,0,1,1,0, 0, 0,1,0,1,0, W0, W0, 0));
        tbl.push_back(mk(0,0,1,1,0, 0, 0,0,0,0,0, W0, W0, 1));
        tbl.push_back(mk(0,0,1,1,0, 0, 0,0,0,0,0, W0, W0, 1));

        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            check($sformatf("row%0d tvalid0", r), 64'(v0), 64'(v.v0));
            check($sformatf("row%0d tvalid1", r), 64'(v1), 64'(v.v1));
            check($sformatf("row%0d busy", r), 64'(busy), 64'(v.busy));
            check($sformatf("row%0d done", r), 64'(done), 64'(v.done));
            check($sformatf("row%0d words_sent", r), 64'(words_sent), 64'(v.words));
            if (v.v0 || v.chk_d) check($sformatf("row%0d tdata0", r), d0, v.d0);
            if (v.v1 || v.chk_d) check($sformatf("row%0d tdata1", r), d1, v.d1);
            if (v.v0) check($sformatf("row%0d tlast0", r), 64'(l0), 64'(v.last));
            if (v.v1) check($sformatf("row%0d tlast1", r), 64'(l1), 64'(v.last));
            start = v.start; stop = v.stop; r0 = v.rdy0; r1 = v.rdy1;
            n_words = v.nw; mode = 1'b0;
            tick();
            start = 0; stop = 0;
        end

        // start and stop together in IDLE: stop wins
        start = 1; stop = 1; n_words = 0;
        tick();
        start = 0; stop = 0;
        check("start_stop_same busy", 64'(busy), 64'd0);

        // PRBS-31, SEED=1: both links seed to 1
        r0 = 1; r1 = 1; mode = 1; n_words = 2; start = 1;
        tick();
        start = 0;
        check("prbs w0 data0", d0, 64'h00000012_00000012);
        check("prbs w0 data1", d1, 64'h00000012_00000012);
        check("prbs w0 last", 64'(l0), 64'd0);
        tick();
        check("prbs w1 data0", d0, 64'h00000104_00000104);
        check("prbs w1 data1", d1, 64'h00000104_00000104);
        check("prbs w1 last", 64'({l0, l1}), 64'd3);
        tick();
        check("prbs done", 64'(done), 64'd1);
        check("prbs words", 64'(words_sent), 64'd2);

        // error injection on link 1 during a continuous counter run
        mode = 0; n_words = 0; start = 1;
        tick();
        start = 0; inject_err = 1; inject_lane = 4'd1;
        ndiff = 0; diff_k = -1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("inj word%0d data0", k), d0, {32'(k + 2), 32'(k + 1)});
            if (d1 !== d0) begin
                ndiff++;
                diff_k = k;
                check("inj diff pattern", d0 ^ d1, 64'h00000001_00000000);
            end
            tick();
            inject_err = 0;
        end
        check("inj diff count", 64'(ndiff), 64'd1);
        check("inj diff word", 64'(diff_k), 64'd2);
        check("inj errs_injected", 64'(errs_injected), 64'd1);
        check("inj words_sent", 64'(words_sent), 64'd8);

        // lane beyond NLINKS is ignored
        inject_err = 1; inject_lane = 4'd3; ndiff = 0;
        for (int k = 0; k < 5; k++) begin
            if (d1 !== d0) ndiff++;
            tick();
            inject_err = 0;
        end
        check("bad lane diff count", 64'(ndiff), 64'd0);
        check("bad lane errs", 64'(errs_injected), 64'd1);

        stop = 1;
        tick();
        stop = 0;
        cyc = 0;
        while (busy && cyc < 10) begin
            tick();
            cyc++;
        end
        check("stop reaches idle", 64'(busy), 64'd0);
        check("stop no tvalid", 64'({v0, v1}), 64'd0);

        // asynchronous reset mid-run
        start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        #2 aresetn = 1'b0;
        #1;
        check("async rst tvalid", 64'({v0, v1}), 64'd0);
        check("async rst words", 64'(words_sent), 64'd0);
        check("async rst busy", 64'(busy), 64'd0);
        #2 aresetn = 1'b1;
        tick();
        start = 1;
        tick();
        start = 0;
        check("restart data0", d0, W0);
        check("restart data1", d1, W0);
        check("restart words", 64'(words_sent), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
